// File: rtl/jstk_input_conditioner_pkg.sv
// Shared definitions for the joystick input conditioner: repeat-FSM encoding,
// channel indices and default parameter values.
package jstk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   localparam int CH_UP    = 0;
   localparam int CH_DOWN  = 1;
   localparam int CH_LEFT  = 2;
   localparam int CH_RIGHT = 3;
   localparam int CH_PRESS = 4;

   localparam int DEF_NUM_CH       = 5;
   localparam int DEF_DB_CYCLES    = 16;
   localparam int DEF_REPEAT_DELAY = 50_000_000;
   localparam int DEF_REPEAT_RATE  = 10_000_000;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/jstk_input_conditioner_if.sv
// Bundle of control inputs and conditioned outputs between the joystick
// conditioner (slave) and whoever drives/consumes it (master).
interface jstk_input_conditioner_if
   import jstk_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH
);
   logic              en;
   logic [NUM_CH-1:0] raw_in;
   logic [NUM_CH-1:0] repeat_en;
   logic [NUM_CH-1:0] level_out;
   logic [NUM_CH-1:0] press_pulse;
   logic [NUM_CH-1:0] release_pulse;

   modport master (
      output en, raw_in, repeat_en,
      input  level_out, press_pulse, release_pulse
   );

   modport slave (
      input  en, raw_in, repeat_en,
      output level_out, press_pulse, release_pulse
   );
endinterface

// File: rtl/jstk_input_conditioner_channel.sv
// One input line: 2-flop synchroniser, counter debouncer and hold-to-repeat
// FSM producing a registered level plus press/release pulses.
module jstk_channel
   import jstk_pkg::*;
#(
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_raw,
   input  logic i_repeat_en,
   output logic o_level,
   output logic o_press,
   output logic o_release
);
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int RCW = $clog2(max_i(REPEAT_DELAY, REPEAT_RATE) + 1);

   logic             r_sync1, r_sync2;
   logic [DBW-1:0]   r_db_cnt;
   logic             r_level;
   rep_state_e       r_state, w_state_nx;
   logic [RCW-1:0]   r_rep_cnt, w_rep_cnt_nx;
   logic             r_press, r_release;
   logic             w_press_nx, w_release_nx;
   logic             w_flip, w_rise, w_fall, w_level_nx;

   // The level flips on the edge where the mismatch run reaches DB_CYCLES samples
   assign w_flip     = (r_sync2 != r_level) && (r_db_cnt == DBW'(DB_CYCLES - 1));
   assign w_rise     = w_flip & ~r_level;
   assign w_fall     = w_flip & r_level;
   assign w_level_nx = r_level ^ w_flip;

   always_comb begin
      w_state_nx   = r_state;
      w_rep_cnt_nx = r_rep_cnt;
      w_press_nx   = 1'b0;
      w_release_nx = 1'b0;
      if (!i_en) begin
         // Park so that re-enabling a held key waits a full delay with no press
         w_state_nx   = w_level_nx ? ST_WAIT : ST_IDLE;
         w_rep_cnt_nx = '0;
      end else if (w_fall) begin
         w_release_nx = 1'b1;
         w_state_nx   = ST_IDLE;
         w_rep_cnt_nx = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  w_press_nx   = 1'b1;
                  w_rep_cnt_nx = '0;
                  w_state_nx   = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!i_repeat_en) begin
                  w_rep_cnt_nx = '0;
               end else if (r_rep_cnt == RCW'(REPEAT_DELAY - 1)) begin
                  w_press_nx   = 1'b1;
                  w_rep_cnt_nx = '0;
                  w_state_nx   = ST_REPEAT;
               end else begin
                  w_rep_cnt_nx = r_rep_cnt + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (!i_repeat_en) begin
                  w_rep_cnt_nx = '0;
                  w_state_nx   = ST_WAIT;
               end else if (r_rep_cnt == RCW'(REPEAT_RATE - 1)) begin
                  w_press_nx   = 1'b1;
                  w_rep_cnt_nx = '0;
               end else begin
                  w_rep_cnt_nx = r_rep_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nx   = ST_IDLE;
               w_rep_cnt_nx = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_db_cnt  <= '0;
         r_level   <= 1'b0;
         r_state   <= ST_IDLE;
         r_rep_cnt <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_db_cnt <= '0;
         end else if (w_flip) begin
            r_db_cnt <= '0;
            r_level  <= ~r_level;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
         r_state   <= w_state_nx;
         r_rep_cnt <= w_rep_cnt_nx;
         r_press   <= w_press_nx;
         r_release <= w_release_nx;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/jstk_input_conditioner.sv
// Joystick/button conditioner: NUM_CH independent channels, each debounced
// with optional auto-repeat; shared enable fanned out to every channel.
module jstk_input_conditioner
   import jstk_pkg::*;
#(
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   jstk_input_conditioner_if.slave  io_bus
);
   logic [NUM_CH-1:0] w_level, w_press, w_release;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      jstk_channel #(
         .DB_CYCLES    (DB_CYCLES),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_en        (io_bus.en),
         .i_raw       (io_bus.raw_in[g]),
         .i_repeat_en (io_bus.repeat_en[g]),
         .o_level     (w_level[g]),
         .o_press     (w_press[g]),
         .o_release   (w_release[g])
      );
   end

   assign io_bus.level_out     = w_level;
   assign io_bus.press_pulse   = w_press;
   assign io_bus.release_pulse = w_release;

endmodule

// File: tb/tb_jstk_input_conditioner.sv
// Bench for jstk_input_conditioner: expected pulses/levels are scheduled into
// a cycle-stamped scoreboard from the stimulus and checked every cycle.
module tb_jstk_input_conditioner;
   import jstk_pkg::*;

   localparam int NCH = 5;
   localparam int DB  = 4;
   localparam int RD  = 20;
   localparam int RR  = 8;
   localparam int LAT = 2 + DB;

   typedef struct {
      int             cyc;
      logic [NCH-1:0] press;
      logic [NCH-1:0] rel;
      bit             chk;
      logic [NCH-1:0] lvl;
   } exp_t;

   typedef struct {
      logic [NCH-1:0] raw;
      logic [NCH-1:0] lvl;
      logic [NCH-1:0] press;
      logic [NCH-1:0] rel;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   mon_on = 1'b0;
   exp_t sb[$];
   vec_t tbl[6];

   jstk_input_conditioner_if #(.NUM_CH(NCH)) bus ();

   jstk_input_conditioner #(
      .NUM_CH(NCH), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: cyc=%0d, required finish before timeout", cyc);
      $fatal(1, "bench timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input exp_t e);
      int i;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
      sb.insert(i, e);
   endtask

   task automatic exp_pulse(input int c, input logic [NCH-1:0] p, input logic [NCH-1:0] r);
      exp_t e;
      e = '{c, p, r, 1'b0, '0};
      push(e);
   endtask

   task automatic exp_lvl(input int c, input logic [NCH-1:0] l);
      exp_t e;
      e = '{c, '0, '0, 1'b1, l};
      push(e);
   endtask

   task automatic monitor();
      logic [NCH-1:0] ep, er, lv;
      bit             lc;
      exp_t           e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            ep = '0; er = '0; lv = '0; lc = 1'b0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
               e = sb.pop_front();
               if (e.cyc < cyc) begin
                  n_vec++; n_bad++;
                  $display("FAIL stale_expect: entry for cyc %0d unchecked at cyc %0d", e.cyc, cyc);
               end else begin
                  ep |= e.press;
                  er |= e.rel;
                  if (e.chk) begin lc = 1'b1; lv = e.lvl; end
               end
            end
            n_vec++;
            if (bus.press_pulse !== ep || bus.release_pulse !== er) begin
               n_bad++;
               $display("FAIL pulses @cyc %0d: press=%h rel=%h, required press=%h rel=%h",
                        cyc, bus.press_pulse, bus.release_pulse, ep, er);
            end
            if (lc) begin
               n_vec++;
               if (bus.level_out !== lv) begin
                  n_bad++;
                  $display("FAIL level @cyc %0d: got %h, required %h", cyc, bus.level_out, lv);
               end
            end
         end
      end
   endtask

   initial begin
      int c, d;
      tbl[0] = '{5'h0A, 5'h0A, 5'h0A, 5'h00};
      tbl[1] = '{5'h15, 5'h15, 5'h15, 5'h0A};
      tbl[2] = '{5'h1F, 5'h1F, 5'h0A, 5'h00};
      tbl[3] = '{5'h10, 5'h10, 5'h00, 5'h0F};
      tbl[4] = '{5'h03, 5'h03, 5'h03, 5'h10};
      tbl[5] = '{5'h00, 5'h00, 5'h00, 5'h03};

      fork monitor(); join_none

      // Reset held for 3 edges with all raw lines high
      bus.en = 1'b1; bus.repeat_en = '0; bus.raw_in = 5'h1F;
      for (int k = 1; k <= 3; k++) exp_lvl(k, '0);
      tick(1);
      mon_on = 1'b1;
      tick(2);
      rst = 1'b0;
      c = cyc;
      exp_lvl(c + LAT - 1, 5'h00);
      exp_lvl(c + LAT, 5'h1F);
      exp_pulse(c + LAT, 5'h1F, '0);
      tick(10);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h1F);
      exp_lvl(cyc + LAT, '0);
      tick(10);

      // Glitch of 3 samples rejected, 4+ accepted
      bus.raw_in = 5'h01;
      tick(3);
      bus.raw_in = '0;
      exp_lvl(cyc + 8, '0);
      tick(10);
      bus.raw_in = 5'h01;
      exp_lvl(cyc + LAT - 1, '0);
      exp_pulse(cyc + LAT, 5'h01, '0);
      exp_lvl(cyc + LAT, 5'h01);
      tick(10);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h01);
      tick(10);

      // Multi-channel patterns
      for (int i = 0; i < 6; i++) begin
         bus.raw_in = tbl[i].raw;
         if ((tbl[i].press | tbl[i].rel) != '0)
            exp_pulse(cyc + LAT, tbl[i].press, tbl[i].rel);
         exp_lvl(cyc + LAT, tbl[i].lvl);
         tick(10);
      end

      // Auto-repeat; the release lands on a repeat tick and wins
      bus.repeat_en = 5'h04;
      bus.raw_in    = 5'h04;
      c = cyc;
      exp_pulse(c + LAT, 5'h04, '0);
      for (int k = RD; k < 60; k += RR) exp_pulse(c + LAT + k, 5'h04, '0);
      exp_lvl(c + 30, 5'h04);
      tick(60);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h04);
      tick(15);

      // Same hold without repeat
      bus.repeat_en = '0;
      bus.raw_in    = 5'h04;
      exp_pulse(cyc + LAT, 5'h04, '0);
      tick(60);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h04);
      tick(15);

      // Enable gating while a key is held
      bus.repeat_en = 5'h02;
      bus.raw_in    = 5'h02;
      exp_pulse(cyc + LAT, 5'h02, '0);
      tick(10);
      bus.en = 1'b0;
      d = cyc;
      exp_lvl(d + 15, 5'h02);
      tick(30);
      bus.en = 1'b1;
      exp_pulse(d + 30 + RD, 5'h02, '0);
      exp_pulse(d + 30 + RD + RR, 5'h02, '0);
      tick(25);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h02);
      tick(15);
      bus.repeat_en = '0;

      // Simultaneous press and release on two channels
      bus.raw_in = 5'h18;
      exp_pulse(cyc + LAT, 5'h18, '0);
      tick(10);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h18);
      tick(10);

      // Reset mid-hold: key reappears with a fresh press
      bus.raw_in = 5'h01;
      exp_pulse(cyc + LAT, 5'h01, '0);
      tick(10);
      rst = 1'b1;
      exp_lvl(cyc + 1, '0);
      tick(2);
      rst = 1'b0;
      exp_lvl(cyc + LAT - 1, '0);
      exp_pulse(cyc + LAT, 5'h01, '0);
      exp_lvl(cyc + LAT, 5'h01);
      tick(10);
      bus.raw_in = '0;
      exp_pulse(cyc + LAT, '0, 5'h01);
      tick(10);

      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
